// File: rtl/ifetchPkg.sv
// Fetch queue entry layout, the NOP word and instruction field positions.
package ifetchPkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   localparam int OPC_LSB = 0;
   localparam int OPC_MSB = 6;
   localparam int F3_LSB  = 12;
   localparam int F3_MSB  = 14;
   localparam int F7_LSB  = 25;
   localparam int F7_MSB  = 31;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ifetch_entry_t;

endpackage

// File: rtl/opcodePkg.sv
// RV32I major opcode encodings shared by fetch and decode.
package opcodePkg;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'h03,
      OP_IMM    = 7'h13,
      OP_AUIPC  = 7'h17,
      OP_STORE  = 7'h23,
      OP_REG    = 7'h33,
      OP_LUI    = 7'h37,
      OP_BRANCH = 7'h63,
      OP_JALR   = 7'h67,
      OP_JAL    = 7'h6F
   } opcode;

endpackage

// File: rtl/ifetch_fifo.sv
// Registered DEPTH-entry queue of fetched words with full/empty/count.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; caller must not push when full without popping.
module ifetch_fifo
   import ifetchPkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push_vld,
   input  ifetch_entry_t          push_dat,
   input  logic                   pop_rdy,
   output ifetch_entry_t          head_dat,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   ifetch_entry_t mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign count    = wr_ptr - rd_ptr;
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (wr_ptr == rd_ptr);
   assign head_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_vld) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop_rdy)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_vld && !flush) mem[wr_ptr[AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/ifetch_buf.sv
// Instruction fetch buffer: credit-limited word fetch into a queue, flushed on redirect.
// Latency: request N, response N+1, inst_valid N+2; IFETCH_BYPASS_EN shows a response to an empty queue at N+1.
// Backpressure: stall holds the head; requests stop once queued plus in-flight words reach DEPTH.
module ifetch_buf
   import ifetchPkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             rst,
   output logic             mem_req,
   output logic [31:0]      mem_addr,
   input  logic             mem_rvalid,
   input  logic [31:0]      mem_rdata,
   input  logic             redirect,
   input  logic [31:0]      redirect_pc,
   input  logic             stall,
   output logic             inst_valid,
   output logic [31:0]      inst,
   output logic [31:0]      inst_pc,
   output opcodePkg::opcode opcode,
   output logic [2:0]       func3,
   output logic [6:0]       func7
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   fetch_pc;
   logic [31:0]   req_addr_q;
   logic          in_flight_q;
   logic          discard_q;
   logic          rsp_vld;
   logic          push_vld;
   logic          pop_rdy;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] occupancy;
   ifetch_entry_t push_dat;
   ifetch_entry_t head_dat;
   ifetch_entry_t out_dat;

   assign rsp_vld   = mem_rvalid & ~(redirect | discard_q);
   assign occupancy = fifo_count + CW'(in_flight_q);
   assign mem_req   = ~rst & ~redirect & (occupancy < CW'(DEPTH));
   assign mem_addr  = fetch_pc;
   assign push_dat  = '{pc: req_addr_q, inst: mem_rdata};
   assign pop_rdy   = ~fifo_empty & ~stall;

`ifdef IFETCH_BYPASS_EN
   logic byp_vld;
   // A response landing on an empty queue is shown directly; it is only queued if stalled.
   assign byp_vld    = fifo_empty & rsp_vld;
   assign push_vld   = rsp_vld & ~(byp_vld & ~stall);
   assign out_dat    = fifo_empty ? push_dat : head_dat;
   assign inst_valid = ~fifo_empty | byp_vld;
`else
   assign push_vld   = rsp_vld;
   assign out_dat    = head_dat;
   assign inst_valid = ~fifo_empty;
`endif

   assign inst    = inst_valid ? out_dat.inst : NOP_INST;
   assign inst_pc = inst_valid ? out_dat.pc : fetch_pc;
   assign opcode  = opcodePkg::opcode'(inst[OPC_MSB:OPC_LSB]);
   assign func3   = inst[F3_MSB:F3_LSB];
   assign func7   = inst[F7_MSB:F7_LSB];

   ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect),
      .push_vld (push_vld),
      .push_dat (push_dat),
      .pop_rdy  (pop_rdy),
      .head_dat (head_dat),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         req_addr_q  <= RESET_PC;
         in_flight_q <= 1'b0;
         discard_q   <= 1'b0;
      end else begin
         in_flight_q <= mem_req;
         if (mem_req) req_addr_q <= fetch_pc;
         if (redirect) begin
            fetch_pc  <= redirect_pc & ~32'h3;
            // Only set if a flushed request has not answered yet; cleared by its response.
            discard_q <= in_flight_q & ~mem_rvalid;
         end else begin
            if (mem_req)    fetch_pc  <= fetch_pc + 32'd4;
            if (mem_rvalid) discard_q <= 1'b0;
         end
      end
   end

   assert property (@(posedge clk) disable iff (rst) !(push_vld && fifo_full && !pop_rdy));
   assert property (@(posedge clk) disable iff (rst) mem_rvalid |-> (in_flight_q || discard_q));

endmodule

// File: tb/tb_ifetch_buf.sv
// Fetch buffer bench: program-order reference model checked every cycle plus literal spot checks.
module tb_ifetch_buf;
   import ifetchPkg::*;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic             clk = 1'b0;
   logic             rst;
   logic             mem_req;
   logic [31:0]      mem_addr;
   logic             mem_rvalid;
   logic [31:0]      mem_rdata;
   logic             redirect;
   logic [31:0]      redirect_pc;
   logic             stall;
   logic             inst_valid;
   logic [31:0]      inst;
   logic [31:0]      inst_pc;
   opcodePkg::opcode opc;
   logic [2:0]       func3;
   logic [6:0]       func7;

   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = -1;
   logic        pend_vld = 1'b0;
   logic [31:0] pend_addr = 32'h0;

   always #5 clk = ~clk;

   ifetch_buf #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .opcode      (opc),
      .func3       (func3),
      .func7       (func7)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0050_0093;
         32'h0000_0004: return 32'h00A0_0113;
         default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
   endtask

   // Memory: answers every request exactly one cycle later.
   initial begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         mem_rvalid = pend_vld;
         mem_rdata  = pend_vld ? mem_word(pend_addr) : 32'hDEAD_BEEF;
      end
   end

   // Reference model: instructions must appear in program order from the last reset/redirect target.
   initial begin
      int          occ;
      logic [31:0] exp_pc;
      logic [31:0] exp_req;
      logic [31:0] w;
      logic        byp, exp_vld, consume, push;
      occ     = 0;
      exp_pc  = RESET_PC;
      exp_req = RESET_PC;
      @(posedge clk);
      forever begin
         @(negedge clk);
         pend_vld  = mem_req;
         pend_addr = mem_addr;
         if (rst) begin
            chk("mem_req_in_rst", 32'(mem_req), 32'h0);
            occ     = 0;
            exp_pc  = RESET_PC;
            exp_req = RESET_PC;
         end else begin
`ifdef IFETCH_BYPASS_EN
            byp = (occ == 0) && mem_rvalid && !redirect;
`else
            byp = 1'b0;
`endif
            exp_vld = (occ > 0) || byp;
            chk("mem_req", 32'(mem_req), 32'((!redirect) && (occ + int'(mem_rvalid) < DEPTH)));
            chk("inst_valid", 32'(inst_valid), 32'(exp_vld));
            if (mem_req) begin
               chk("mem_addr", mem_addr, exp_req);
               exp_req = exp_req + 32'd4;
            end
            if (exp_vld) begin
               w = mem_word(exp_pc);
               chk("inst_pc", inst_pc, exp_pc);
               chk("inst", inst, w);
               chk("opcode", 32'(opc), 32'(w[6:0]));
               chk("func3", 32'(func3), 32'(w[14:12]));
               chk("func7", 32'(func7), 32'(w[31:25]));
            end else begin
               chk("inst_nop", inst, NOP_INST);
            end
            if (redirect) begin
               occ     = 0;
               exp_pc  = redirect_pc & ~32'h3;
               exp_req = redirect_pc & ~32'h3;
            end else begin
               consume = exp_vld && !stall;
               push    = mem_rvalid && !(byp && !stall);
               if (consume) exp_pc = exp_pc + 32'd4;
               occ = occ + int'(push) - int'(consume);
            end
         end
      end
   end

   // Directed stimulus with hand-computed literal expectations.
   initial begin
      rst         = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_inst_valid", 32'(inst_valid), 32'h0);
      chk("rst_inst", inst, 32'h0000_0013);
      chk("rst_inst_pc", inst_pc, RESET_PC);
      chk("rst_opcode", 32'(opc), 32'h13);
      chk("rst_func3", 32'(func3), 32'h0);
      chk("rst_func7", 32'(func7), 32'h0);
      @(posedge clk);
      #1;
      for (int c = 0; c < 300; c++) begin
         cyc         = c;
         rst         = (c == 14);
         stall       = (c inside {[6:8], [12:14], [24:25]}) || (c >= 40 && (c % 5) < 2);
         redirect    = (c == 19) || (c == 25) || (c == 30) || (c >= 40 && (c % 37) == 0);
         redirect_pc = (c == 19) ? 32'h0000_0100 :
                       (c == 25) ? 32'h0000_0203 :
                       (c == 30) ? 32'hFFFF_FFF8 : 32'(c) * 32'h40 + 32'h2;
         @(negedge clk);
`ifdef IFETCH_BYPASS_EN
         if (c == 1) begin
            chk("byp_valid", 32'(inst_valid), 32'h1);
            chk("byp_inst", inst, 32'h0050_0093);
            chk("byp_pc", inst_pc, 32'h0);
         end
`else
         case (c)
            0: begin chk("l_req0", 32'(mem_req), 32'h1); chk("l_addr0", mem_addr, 32'h0); end
            1: begin chk("l_addr1", mem_addr, 32'h4); chk("l_vld1", 32'(inst_valid), 32'h0); end
            2: begin
               chk("l_vld2", 32'(inst_valid), 32'h1);
               chk("l_pc2", inst_pc, 32'h0);
               chk("l_inst2", inst, 32'h0050_0093);
               chk("l_opc2", 32'(opc), 32'h13);
            end
            3: begin chk("l_pc3", inst_pc, 32'h4); chk("l_inst3", inst, 32'h00A0_0113); end
            6, 7: chk("l_stall_pc", inst_pc, 32'hC);
            8: begin chk("l_stall_pc8", inst_pc, 32'hC); chk("l_full_req", 32'(mem_req), 32'h0); end
            9: chk("l_drain9", inst_pc, 32'hC);
            10: chk("l_drain10", inst_pc, 32'h10);
            13: begin chk("l_full13", 32'(inst_valid), 32'h1); chk("l_pc13", inst_pc, 32'h14); end
            15: begin
               chk("l_rst_vld", 32'(inst_valid), 32'h0);
               chk("l_rst_inst", inst, 32'h0000_0013);
               chk("l_rst_addr", mem_addr, RESET_PC);
               chk("l_rst_req", 32'(mem_req), 32'h1);
            end
            19: chk("l_redir_req", 32'(mem_req), 32'h0);
            20: chk("l_redir_addr", mem_addr, 32'h100);
            22: chk("l_redir_pc", inst_pc, 32'h100);
            26: begin chk("l_align_addr", mem_addr, 32'h200); chk("l_align_vld", 32'(inst_valid), 32'h0); end
            28: chk("l_align_pc", inst_pc, 32'h200);
            34: begin chk("l_wrap_req", 32'(mem_req), 32'h1); chk("l_wrap_addr", mem_addr, 32'h0); end
            36: chk("l_wrap_inst", inst, 32'h0050_0093);
            default: ;
         endcase
`endif
         @(posedge clk);
         #1;
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
